text_console_writer: RTL
========================

# text_console_writer

Parametrised successor to the fixed 15×40 character feeder/plane pair. It accepts a character stream over a valid/ready handshake and interprets control codes (CR, LF, BS, FF). It keeps a cursor with line wrap, stores character plus colour attribute per cell, and scrolls the screen in hardware when output runs past the last row. It sits between the character source and the pixel encoder, which reads cells through a dedicated read port.

## Interface
- ROWS, 15, number of text rows
- COLS, 40, characters per row
- CHAR_W, 8, character id width
- ATTR_W, 4, per-cell colour attribute width
- DEFAULT_ATTR, 4'hF, attribute written into blanked cells
- ROW_W / COL_W / ADDR_W, derived: $clog2(ROWS) / $clog2(COLS) / $clog2(ROWS*COLS)
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  character present
- in_ready  out  1  block can accept this cycle
- in_char  in  CHAR_W  character id or control code
- in_attr  in  ATTR_W  attribute for a printable character
- rd_row  in  ROW_W  pixel-side read row
- rd_col  in  COL_W  pixel-side read column
- rd_char  out  CHAR_W  cell character, 1-cycle latency
- rd_attr  out  ATTR_W  cell attribute, 1-cycle latency
- cursor_row  out  ROW_W  current cursor row
- cursor_col  out  COL_W  current cursor column
- busy  out  1  scroll or clear in progress (equals !in_ready)

## Operation
- Cell address = row*COLS + col. Blank cell = char 0x20, DEFAULT_ATTR.
- A character is accepted on a rising edge with in_valid && in_ready. in_ready = (state == IDLE).
- Printable (any code other than those below): write {in_char, in_attr} at the cursor, then col+1.
  - At col == COLS-1: col = 0 and advance the row.
- 0x0D CR: col = 0. No write.
- 0x0A LF: col = 0, advance the row.
- 0x08 BS: if col > 0, col-1 and blank the new position. At col 0: no effect, no write.
- 0x0C FF: enter CLEAR_ALL. Cursor goes to (0,0).
- Row advance: if row < ROWS-1, row+1. Otherwise the row stays ROWS-1 and the state goes to SCROLL.
- FSM states:
  - CLEAR_ALL: blank addresses 0..ROWS*COLS-1, one per cycle, then IDLE.
  - IDLE: accepts input.
  - SCROLL: copy cell a+COLS to cell a for a = 0..(ROWS-1)*COLS-1. Pipelined, one cell per cycle through the second read port. Then CLEAR_ROW.
  - CLEAR_ROW: blank the last row, COLS cycles, then IDLE.
- The pixel read port is always live. During SCROLL or CLEAR it returns intermediate contents, which is acceptable.
- Read and write to the same cell in the same cycle: read returns the old data.
- Reset: cursor = (0,0), in_ready = 0, busy = 1, rd_char/rd_attr = 0.
  - CLEAR_ALL starts on the first cycle after reset deasserts.
  - Reset asserted in any state, including mid-scroll, aborts the operation and restarts as above.

## Timing
- Throughput in IDLE: one character per cycle.
- The cell write and cursor update commit on the accepting edge. The new cursor is visible the following cycle.
- A printable write can be read back on the read port two cycles after acceptance.
- Accepting an LF, wrap or FF drops in_ready from the next cycle:
  - SCROLL plus CLEAR_ROW: (ROWS-1)*COLS + 1 + COLS cycles (601 at defaults).
  - CLEAR_ALL: ROWS*COLS cycles (600 at defaults).
- After reset deasserts, in_ready rises ROWS*COLS cycles later.
- Counter widths: the address counter is ADDR_W bits. No counter wraps past its terminal count; each state exits on equality.

## Structure
- Shared package text_console_pkg holds:
  - control-code constants (CC_CR, CC_LF, CC_BS, CC_FF)
  - BLANK_CHAR (0x20)
  - the state enum (CLEAR_ALL, IDLE, SCROLL, CLEAR_ROW)
- Sub-module char_ram:
  - ROWS*COLS × (CHAR_W+ATTR_W) storage
  - one synchronous write port
  - two synchronous read ports: pixel and scroll-copy
- The top level holds the FSM, cursor logic and address counter.

## Test plan
- Reset 1 cycle, release: in_ready = 0 for 600 cycles, then 1. All 600 cells read 0x20/0xF. Cursor = (0,0).
- Send 0x41 with attr 0x3: cell(0,0) = 0x41/0x3, cursor = (0,1). Then CR: cursor = (0,0), cell unchanged.
- Send 40 printables 0x30..0x57 back-to-back with in_valid held: all accepted in 40 cycles. Cursor = (1,0). Row 0 holds the sequence.
- Fill rows 0..14 with row-number chars, then LF at (14,7):
  - in_ready low for 601 cycles
  - row 0 = old row 1, row 13 = old row 14, row 14 blank
  - cursor = (14,0)
- BS at (2,5): cursor = (2,4), cell(2,4) blank. BS at (2,0): no change. FF: busy for 600 cycles, all cells blank, cursor = (0,0).
- Assert reset 100 cycles into a scroll: cursor = (0,0) immediately. CLEAR_ALL completes in 600 cycles. No stale row content remains.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console writer and its cell store.
package text_console_pkg;

  localparam logic [7:0] CC_BS      = 8'h08;
  localparam logic [7:0] CC_LF      = 8'h0A;
  localparam logic [7:0] CC_FF      = 8'h0C;
  localparam logic [7:0] CC_CR      = 8'h0D;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    SCROLL,
    CLEAR_ROW
  } state_t;

endpackage

// File: rtl/text_console_writer_char_ram.sv
// Cell store: one write port, a pixel read port and a scroll-copy read port.
// Both reads are registered; a read of a cell being written returns the old contents.
module char_ram #(
  parameter int DEPTH  = 600,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [WIDTH-1:0]  a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] a_data_q;
  logic [WIDTH-1:0] b_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the pixel-side output register is reset so the encoder sees zeros after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_data_q <= '0;
    end else begin
      a_data_q <= mem[a_addr];
    end
  end

  always_ff @(posedge clk) begin
    b_data_q <= mem[b_addr];
  end

  assign a_data = a_data_q;
  assign b_data = b_data_q;

endmodule

// File: rtl/text_console_writer.sv
// Character-stream console: control-code interpretation, cursor with wrap,
// hardware scroll and full-screen clear over a ROWS x COLS cell store.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int              ROWS         = 15,
  parameter int              COLS         = 40,
  parameter int              CHAR_W       = 8,
  parameter int              ATTR_W       = 4,
  parameter logic [ATTR_W-1:0] DEFAULT_ATTR = 4'hF,
  parameter int              ROW_W        = $clog2(ROWS),
  parameter int              COL_W        = $clog2(COLS),
  parameter int              ADDR_W       = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [ATTR_W-1:0] in_attr,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic [ATTR_W-1:0] rd_attr,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col,
  output logic              busy
);

  localparam int DATA_W = CHAR_W + ATTR_W;
  localparam int CELLS  = ROWS * COLS;

  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(COLS - 1);
  localparam logic [DATA_W-1:0] BLANK_CELL    = {CHAR_W'(BLANK_CHAR), DEFAULT_ATTR};

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;

  logic               we;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [ADDR_W-1:0]  scr_addr;
  logic [DATA_W-1:0]  scr_data;
  logic [DATA_W-1:0]  pix_data;
  logic               do_adv;

  char_ram #(
    .DEPTH  (CELLS),
    .WIDTH  (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .a_addr  (cell_addr(rd_row, rd_col)),
    .a_data  (pix_data),
    .b_addr  (scr_addr),
    .b_data  (scr_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    row_d    = row_q;
    col_d    = col_q;
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = BLANK_CELL;
    scr_addr = '0;
    do_adv   = 1'b0;

    unique case (state_q)
      CLEAR_ALL: begin
        we      = 1'b1;
        wr_addr = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      IDLE: begin
        if (in_valid) begin
          if (in_char == CHAR_W'(CC_CR)) begin
            col_d = '0;
          end else if (in_char == CHAR_W'(CC_LF)) begin
            col_d  = '0;
            do_adv = 1'b1;
          end else if (in_char == CHAR_W'(CC_BS)) begin
            if (col_q != '0) begin
              col_d   = col_q - COL_W'(1);
              we      = 1'b1;
              wr_addr = cell_addr(row_q, col_q - COL_W'(1));
            end
          end else if (in_char == CHAR_W'(CC_FF)) begin
            state_d = CLEAR_ALL;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            we      = 1'b1;
            wr_addr = cell_addr(row_q, col_q);
            wr_data = {in_char, in_attr};
            if (col_q == LAST_COL) begin
              col_d  = '0;
              do_adv = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      // Read of a+COLS issues at count a; its write to a lands one cycle later.
      SCROLL: begin
        if (addr_q != LAST_ROW_BASE) begin
          scr_addr = addr_q + ADDR_W'(COLS);
        end
        if (addr_q != '0) begin
          we      = 1'b1;
          wr_addr = addr_q - ADDR_W'(1);
          wr_data = scr_data;
        end
        if (addr_q == LAST_ROW_BASE) begin
          state_d = CLEAR_ROW;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      CLEAR_ROW: begin
        we      = 1'b1;
        wr_addr = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        addr_d  = '0;
      end
    endcase

    if (do_adv) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + ROW_W'(1);
      end else begin
        state_d = SCROLL;
        addr_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ALL;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign rd_char    = pix_data[DATA_W-1:ATTR_W];
  assign rd_attr    = pix_data[ATTR_W-1:0];

endmodule
